// File: rtl/data_bus_interconnect.sv
// Parametrised 1-master/N-slave data-bus interconnect with in-order response tracking.
// Optional unmapped-access logging enabled by defining DATA_BUS_ERR_LOG_EN.
module data_bus_interconnect #(
    parameter int N_SLAVES        = 8,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLAVE_BASE = {
        32'h0101_0000, 32'h0100_3000, 32'h0100_2000, 32'h0100_1000,
        32'h0100_0000, 32'h0010_0000, 32'h0001_0000, 32'h0000_0000
    },
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLAVE_MASK = {
        32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000,
        32'hFFFF_F000, 32'hFFFF_C000, 32'hFFFF_C000, 32'hFFFF_F000
    }
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m_req,
    output logic                       m_gnt,
    input  logic [ADDR_W-1:0]          m_addr,
    input  logic                       m_we,
    input  logic [DATA_W/8-1:0]        m_be,
    input  logic [DATA_W-1:0]          m_wdata,
    output logic                       m_rvalid,
    output logic                       m_err,
    output logic [DATA_W-1:0]          m_rdata,
    output logic [N_SLAVES-1:0]        s_req,
    input  logic [N_SLAVES-1:0]        s_gnt,
    output logic [ADDR_W-1:0]          s_addr,
    output logic                       s_we,
    output logic [DATA_W/8-1:0]        s_be,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic [N_SLAVES-1:0]        s_rvalid,
    input  logic [N_SLAVES-1:0]        s_err,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
`ifdef DATA_BUS_ERR_LOG_EN
    output logic [ADDR_W-1:0]          err_addr,
    output logic                       err_we,
    output logic                       err_valid,
    input  logic                       err_clr,
`endif
    output logic                       protocol_err
);

    localparam int IDX_W = $clog2(N_SLAVES + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [IDX_W-1:0] ERR_IDX  = IDX_W'(N_SLAVES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             accept;
    logic             push;
    logic             pop;
    logic             stray;

    assign s_addr  = m_addr;
    assign s_we    = m_we;
    assign s_be    = m_be;
    assign s_wdata = m_wdata;

    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);
    assign head  = fifo_q[rd_ptr];

    // Descending scan so the lowest matching index wins.
    always_comb begin
        sel = ERR_IDX;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

    always_comb begin
        m_rvalid = 1'b0;
        m_err    = 1'b0;
        m_rdata  = '0;
        pop      = 1'b0;
        stray    = 1'b0;
        if (!empty && head == ERR_IDX) begin
            m_rvalid = 1'b1;
            m_err    = 1'b1;
            pop      = 1'b1;
        end
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!empty && head == IDX_W'(i)) begin
                m_rvalid = s_rvalid[i];
                m_err    = s_err[i];
                m_rdata  = s_rdata[i*DATA_W +: DATA_W];
                pop      = s_rvalid[i];
            end else if (s_rvalid[i]) begin
                stray = 1'b1;
            end
        end
    end

    assign protocol_err = stray & rst_n;

    // A pop in the same cycle frees a slot, so a full FIFO may still accept.
    assign accept = !full || pop;

    always_comb begin
        s_req = '0;
        m_gnt = 1'b0;
        if (rst_n && accept) begin
            if (sel == ERR_IDX) begin
                m_gnt = m_req;
            end else begin
                for (int i = 0; i < N_SLAVES; i++) begin
                    if (sel == IDX_W'(i)) begin
                        s_req[i] = m_req;
                        m_gnt    = s_gnt[i];
                    end
                end
            end
        end
    end

    assign push = m_req && m_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= sel;
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef DATA_BUS_ERR_LOG_EN
    // Only the first unmapped access is held until software clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr  <= '0;
            err_we    <= 1'b0;
            err_valid <= 1'b0;
        end else if (push && sel == ERR_IDX && !err_valid) begin
            err_addr  <= m_addr;
            err_we    <= m_we;
            err_valid <= 1'b1;
        end else if (err_clr) begin
            err_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_data_bus_interconnect.sv
// Directed self-checking bench for data_bus_interconnect.
// Exercises decode, in-order responses, error target, backpressure and reset.
module tb_data_bus_interconnect;

    logic         clk;
    logic         rst_n;
    logic         m_req;
    logic         m_gnt;
    logic [31:0]  m_addr;
    logic         m_we;
    logic [3:0]   m_be;
    logic [31:0]  m_wdata;
    logic         m_rvalid;
    logic         m_err;
    logic [31:0]  m_rdata;
    logic [7:0]   s_req;
    logic [7:0]   s_gnt;
    logic [31:0]  s_addr;
    logic         s_we;
    logic [3:0]   s_be;
    logic [31:0]  s_wdata;
    logic [7:0]   s_rvalid;
    logic [7:0]   s_err;
    logic [255:0] s_rdata;
    logic         protocol_err;
`ifdef DATA_BUS_ERR_LOG_EN
    logic [31:0]  err_addr;
    logic         err_we;
    logic         err_valid;
    logic         err_clr;
`endif

    int compared;
    int mismatched;

    data_bus_interconnect dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_req        (m_req),
        .m_gnt        (m_gnt),
        .m_addr       (m_addr),
        .m_we         (m_we),
        .m_be         (m_be),
        .m_wdata      (m_wdata),
        .m_rvalid     (m_rvalid),
        .m_err        (m_err),
        .m_rdata      (m_rdata),
        .s_req        (s_req),
        .s_gnt        (s_gnt),
        .s_addr       (s_addr),
        .s_we         (s_we),
        .s_be         (s_be),
        .s_wdata      (s_wdata),
        .s_rvalid     (s_rvalid),
        .s_err        (s_err),
        .s_rdata      (s_rdata),
`ifdef DATA_BUS_ERR_LOG_EN
        .err_addr     (err_addr),
        .err_we       (err_we),
        .err_valid    (err_valid),
        .err_clr      (err_clr),
`endif
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n    = 1'b0;
        m_req    = 1'b0;
        m_addr   = '0;
        m_we     = 1'b0;
        m_be     = 4'hF;
        m_wdata  = 32'h1234_5678;
        s_gnt    = '0;
        s_rvalid = '0;
        s_err    = '0;
        s_rdata  = '0;
`ifdef DATA_BUS_ERR_LOG_EN
        err_clr  = 1'b0;
`endif
        #2;
        chk("rst_m_gnt", {31'b0, m_gnt}, 32'd0);
        chk("rst_m_rvalid", {31'b0, m_rvalid}, 32'd0);
        chk("rst_m_err", {31'b0, m_err}, 32'd0);
        chk("rst_m_rdata", m_rdata, 32'd0);
        chk("rst_s_req", {24'b0, s_req}, 32'd0);
        chk("rst_perr", {31'b0, protocol_err}, 32'd0);
`ifdef DATA_BUS_ERR_LOG_EN
        chk("rst_err_valid", {31'b0, err_valid}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // data RAM read, response two cycles after grant
        cyc();
        m_req = 1'b1; m_addr = 32'h0010_0004; s_gnt = 8'h04;
        #1;
        chk("t1_s_req", {24'b0, s_req}, 32'h04);
        chk("t1_m_gnt", {31'b0, m_gnt}, 32'd1);
        chk("t1_s_addr", s_addr, 32'h0010_0004);
        cyc();
        m_req = 1'b0; s_gnt = '0;
        #1;
        chk("t1_wait_rvalid", {31'b0, m_rvalid}, 32'd0);
        cyc();
        s_rvalid = 8'h04; s_rdata[2*32 +: 32] = 32'hA5A5_0001;
        #1;
        chk("t1_rvalid", {31'b0, m_rvalid}, 32'd1);
        chk("t1_rdata", m_rdata, 32'hA5A5_0001);
        chk("t1_err", {31'b0, m_err}, 32'd0);
        chk("t1_perr", {31'b0, protocol_err}, 32'd0);
        cyc();
        s_rvalid = '0;
        #1;
        chk("t1_empty_rvalid", {31'b0, m_rvalid}, 32'd0);

        // UART then boot ROM; ROM answers first
        cyc();
        m_req = 1'b1; m_addr = 32'h0100_2000; s_gnt = 8'h20;
        #1;
        chk("t2_s_req_uart", {24'b0, s_req}, 32'h20);
        chk("t2_gnt_uart", {31'b0, m_gnt}, 32'd1);
        cyc();
        m_addr = 32'h0000_0010; s_gnt = 8'h01;
        #1;
        chk("t2_s_req_rom", {24'b0, s_req}, 32'h01);
        chk("t2_gnt_rom", {31'b0, m_gnt}, 32'd1);
        cyc();
        m_req = 1'b0; s_gnt = '0;
        s_rvalid = 8'h01; s_rdata[0 +: 32] = 32'h0000_B007;
        #1;
        chk("t2_perr_pulse", {31'b0, protocol_err}, 32'd1);
        chk("t2_ooo_rvalid", {31'b0, m_rvalid}, 32'd0);
        cyc();
        s_rvalid = 8'h20; s_rdata[5*32 +: 32] = 32'h0000_0A57;
        #1;
        chk("t2_uart_rvalid", {31'b0, m_rvalid}, 32'd1);
        chk("t2_uart_rdata", m_rdata, 32'h0000_0A57);
        chk("t2_perr_clear", {31'b0, protocol_err}, 32'd0);
        cyc();
        s_rvalid = 8'h01;
        #1;
        chk("t2_rom_rvalid", {31'b0, m_rvalid}, 32'd1);
        chk("t2_rom_rdata", m_rdata, 32'h0000_B007);
        cyc();
        s_rvalid = '0;
        #1;
        chk("t2_drained", {31'b0, m_rvalid}, 32'd0);

        // unmapped read answered internally
        cyc();
        m_req = 1'b1; m_addr = 32'h0200_0000; s_gnt = 8'hFF;
        #1;
        chk("t3_gnt", {31'b0, m_gnt}, 32'd1);
        chk("t3_s_req", {24'b0, s_req}, 32'd0);
        cyc();
        m_req = 1'b0; s_gnt = '0;
        #1;
        chk("t3_rvalid", {31'b0, m_rvalid}, 32'd1);
        chk("t3_err", {31'b0, m_err}, 32'd1);
        chk("t3_rdata", m_rdata, 32'd0);
        cyc();
        #1;
        chk("t3_popped", {31'b0, m_rvalid}, 32'd0);

        // backpressure at MAX_OUTSTANDING=2
        cyc();
        m_req = 1'b1; m_addr = 32'h0000_0010; s_gnt = 8'h01;
        #1;
        chk("t4_gnt1", {31'b0, m_gnt}, 32'd1);
        cyc();
        m_addr = 32'h0001_0000; s_gnt = 8'h02;
        #1;
        chk("t4_gnt2", {31'b0, m_gnt}, 32'd1);
        cyc();
        m_addr = 32'h0010_0000; s_gnt = 8'h04;
        #1;
        chk("t4_full_gnt", {31'b0, m_gnt}, 32'd0);
        chk("t4_full_s_req", {24'b0, s_req}, 32'd0);
        cyc();
        #1;
        chk("t4_still_full", {31'b0, m_gnt}, 32'd0);
        cyc();
        s_rvalid = 8'h01; s_rdata[0 +: 32] = 32'h0000_1111;
        #1;
        chk("t4_pop_rdata", m_rdata, 32'h0000_1111);
        chk("t4_pop_gnt", {31'b0, m_gnt}, 32'd1);
        chk("t4_pop_s_req", {24'b0, s_req}, 32'h04);
        cyc();
        m_req = 1'b0; s_gnt = '0;
        s_rvalid = 8'h02; s_rdata[32 +: 32] = 32'h0000_2222;
        #1;
        chk("t4_second_rvalid", {31'b0, m_rvalid}, 32'd1);
        chk("t4_second_rdata", m_rdata, 32'h0000_2222);
        cyc();
        s_rvalid = 8'h04; s_rdata[2*32 +: 32] = 32'h0000_3333;
        #1;
        chk("t4_third_rdata", m_rdata, 32'h0000_3333);
        chk("t4_third_perr", {31'b0, protocol_err}, 32'd0);
        cyc();
        s_rvalid = '0;
        #1;
        chk("t4_drained", {31'b0, m_rvalid}, 32'd0);

        // reset with two transactions outstanding
        cyc();
        m_req = 1'b1; m_addr = 32'h0000_0010; s_gnt = 8'h01;
        cyc();
        m_addr = 32'h0001_0000; s_gnt = 8'h02;
        cyc();
        m_addr = 32'h0000_0010; s_gnt = 8'h01;
        rst_n = 1'b0;
        s_rvalid = 8'h01;
        #1;
        chk("t5_rst_rvalid", {31'b0, m_rvalid}, 32'd0);
        chk("t5_rst_gnt", {31'b0, m_gnt}, 32'd0);
        chk("t5_rst_s_req", {24'b0, s_req}, 32'd0);
        chk("t5_rst_rdata", m_rdata, 32'd0);
        @(negedge clk);
        m_req = 1'b0; s_gnt = '0; s_rvalid = '0;
        rst_n = 1'b1;
        cyc();
        s_rvalid = 8'h02;
        #1;
        chk("t5_late_perr", {31'b0, protocol_err}, 32'd1);
        chk("t5_late_rvalid", {31'b0, m_rvalid}, 32'd0);
        cyc();
        s_rvalid = '0;

`ifdef DATA_BUS_ERR_LOG_EN
        // first unmapped access is logged, second is not
        cyc();
        m_req = 1'b1; m_addr = 32'h0300_0000; m_we = 1'b1;
        cyc();
        m_addr = 32'h0400_0000; m_we = 1'b0;
        #1;
        chk("t6_valid", {31'b0, err_valid}, 32'd1);
        chk("t6_addr1", err_addr, 32'h0300_0000);
        cyc();
        m_req = 1'b0;
        #1;
        chk("t6_addr_kept", err_addr, 32'h0300_0000);
        chk("t6_we_kept", {31'b0, err_we}, 32'd1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        #1;
        chk("t6_cleared", {31'b0, err_valid}, 32'd0);
`endif

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
